// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg: default geometry and parameter legality helper for the pipelined CLA.
// Latency: none (constants and an elaboration-time function only).
// Backpressure: none.
`timescale 1ns/1ps
package pipelined_cla_adder_pkg;

  localparam int CLA_DEFAULT_WIDTH = 32;
  localparam int CLA_DEFAULT_GROUP = 8;
  localparam int CLA_GROUP_MIN     = 2;
  localparam int CLA_GROUP_MAX     = 16;

  // A legal geometry splits WIDTH into a whole number of GROUP-bit slices.
  function automatic bit cla_params_legal(input int width, input int group);
    return (group >= CLA_GROUP_MIN) && (group <= CLA_GROUP_MAX) &&
           (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// cla_group: one N-bit carry-lookahead slice with flat generate/propagate carry terms.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
//
// Ports:
//   a, b      N-bit operand slices (b already conditioned for subtract)
//   ci        carry into bit 0 of the slice
//   s         N-bit slice sum
//   co        carry out of bit N-1
//   c_msb_in  carry into bit N-1 (used for signed overflow on the top slice)
`timescale 1ns/1ps
module cla_group
  import pipelined_cla_adder_pkg::*;
#(
  parameter int N = CLA_DEFAULT_GROUP
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Each carry is a flat sum of products: c[i] = OR_j (g[j] & p[i-1:j+1]) | (p[i-1:0] & ci).
  // No carry depends on a previously computed carry, so depth stays two-level per bit.
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= N; i++) begin
      term = ci;
      for (int k = 0; k < i; k++) term = term & p[k];
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  assign s        = a ^ b ^ c[N-1:0];
  assign co       = c[N];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract built from GROUP-bit lookahead slices, one slice per stage.
// Latency: STAGES = WIDTH/GROUP cycles from accept to out_valid; one beat per cycle throughput.
// Backpressure: global stall -- when out_valid & ~out_ready every stage holds and in_ready drops.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, cin, op_sub)
//   a, b                  WIDTH-bit operands
//   cin                   carry-in for add, borrow-in for subtract
//   op_sub                0 = a+b+cin, 1 = a-b-cin
//   out_valid / out_ready result handshake
//   sum                   WIDTH-bit result
//   cout                  carry out of the top bit (subtract: 1 = no borrow)
//   ovf                   two's-complement overflow
//   zero                  sum == 0
`timescale 1ns/1ps
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = CLA_DEFAULT_WIDTH,
  parameter int GROUP = CLA_DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / GROUP;

  if (!cla_params_legal(WIDTH, GROUP)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and GROUP must be 2..16");
  end

  // Per-stage state. a/b carry the still-unprocessed upper slices forward, s accumulates
  // finished slices from the bottom up, c is the carry into the next slice. ovf/zero are
  // only meaningful in the last stage, where s is complete.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic             zero;
  } stage_t;

  stage_t            pipe [STAGES];
  logic [STAGES-1:0] vld;
  logic              advance;
  stage_t            in_cond;

  assign out_valid = vld[STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Subtract is a + ~b + ~cin, so the same adder serves both ops and cout means "no borrow".
  always_comb begin
    in_cond   = '0;
    in_cond.a = a;
    in_cond.b = op_sub ? ~b : b;
    in_cond.c = op_sub ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           st_d;
    stage_t           st_r;
    logic             src_vld;
    logic             vld_r;
    logic [GROUP-1:0] slice_s;
    logic             slice_co;
    logic             slice_cm;

    if (k == 0) begin : g_head
      assign src     = in_cond;
      assign src_vld = in_valid;
    end else begin : g_body
      assign src     = pipe[k-1];
      assign src_vld = vld[k-1];
    end

    cla_group #(
      .N(GROUP)
    ) u_cla_group (
      .a        (src.a[k*GROUP +: GROUP]),
      .b        (src.b[k*GROUP +: GROUP]),
      .ci       (src.c),
      .s        (slice_s),
      .co       (slice_co),
      .c_msb_in (slice_cm)
    );

    always_comb begin
      st_d                     = src;
      st_d.s[k*GROUP +: GROUP] = slice_s;
      st_d.c                   = slice_co;
      st_d.ovf                 = slice_co ^ slice_cm;
      st_d.zero                = (st_d.s == '0);
    end

    // Data only loads with a real beat, so whatever sits on the operand ports during a
    // bubble never reaches the registers; outputs simply keep their last value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= 1'b0;
        st_r  <= '0;
      end else if (advance) begin
        vld_r <= src_vld;
        if (src_vld) st_r <= st_d;
      end
    end

    assign pipe[k] = st_r;
    assign vld[k]  = vld_r;
  end

  assign sum  = pipe[STAGES-1].s;
  assign cout = pipe[STAGES-1].c;
  assign ovf  = pipe[STAGES-1].ovf;
  assign zero = pipe[STAGES-1].zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

  localparam int W       = 32;
  localparam int N_SMALL = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32/8 device
  logic         in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  // shared stimulus for the 8/4 and 8/8 devices
  logic       s_in_valid, s_cin, s_op_sub, s_out_ready;
  logic [7:0] s_a, s_b;
  logic       g4_in_ready, g4_out_valid, g4_cout, g4_ovf, g4_zero;
  logic [7:0] g4_sum;
  logic       g8_in_ready, g8_out_valid, g8_cout, g8_ovf, g8_zero;
  logic [7:0] g8_sum;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) u_dut_g4 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(g4_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .op_sub(s_op_sub), .out_valid(g4_out_valid), .out_ready(s_out_ready),
    .sum(g4_sum), .cout(g4_cout), .ovf(g4_ovf), .zero(g4_zero)
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut_g8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(g8_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .op_sub(s_op_sub), .out_valid(g8_out_valid), .out_ready(s_out_ready),
    .sum(g8_sum), .cout(g8_cout), .ovf(g8_ovf), .zero(g8_zero)
  );

  // Reference: plain integer arithmetic on w-bit unsigned and signed views of the operands.
  function automatic res_t model(input int w, input longint unsigned av, input longint unsigned bv,
                                 input bit ci, input bit sub);
    longint m, ua, ub, cl, ur, sa, sb, sr;
    res_t   r;
    m      = longint'(1) << w;
    ua     = av;
    ub     = bv;
    cl     = ci;
    ur     = sub ? (ua - ub - cl) : (ua + ub + cl);
    r.cout = sub ? (ur >= 0) : (ur >= m);
    r.sum  = 32'(((ur % m) + m) % m);
    sa     = (ua >= m / 2) ? ua - m : ua;
    sb     = (ub >= m / 2) ? ub - m : ub;
    sr     = sub ? (sa - sb - cl) : (sa + sb + cl);
    r.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    r.zero = (r.sum == 0);
    return r;
  endfunction

  task automatic test_reset();
    #3;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if ({sum, cout, ovf, zero} !== 35'd0) begin
      n_fail++; $display("FAIL reset_data: got sum=%h c=%b o=%b z=%b expected all 0", sum, cout, ovf, zero);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if ({g4_out_valid, g8_out_valid, g4_sum, g8_sum} !== 18'd0) begin
      n_fail++; $display("FAIL reset_small: got v4=%b v8=%b s4=%h s8=%h expected 0", g4_out_valid, g8_out_valid, g4_sum, g8_sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd5, 32'd3, 32'h80000000};
    logic [31:0] tb [8] = '{32'd1,        32'd7, 32'd1,        32'd1,        32'd2, 32'd5, 32'd3, 32'h80000000};
    logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tsub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] es [8] = '{32'h0, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'd4, 32'hFFFFFFFF, 32'h0, 32'h0};
    // {cout, ovf, zero}
    logic [2:0]  ef [8] = '{3'b101, 3'b000, 3'b110, 3'b010, 3'b000, 3'b000, 3'b101, 3'b111};
    int lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = tc[i]; op_sub = tsub[i];
      @(negedge clk);
      // Junk on the operand ports while idle must not matter.
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat != 4) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d cycles expected 4", i, lat);
      end
      n_checks++;
      if ({sum, cout, ovf, zero} !== {es[i], ef[i]}) begin
        n_fail++; $display("FAIL directed_result[%0d]: got sum=%h cov z=%b%b%b expected sum=%h cov z=%b", i, sum, cout, ovf, zero, es[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t        q[$];
    res_t        exp;
    int          sent = 0, got = 0, cyc = 0, stall_left = 0, ready_low = 0;
    bit          stall_done = 0, was_stalled = 0, last_acc = 1;
    logic [31:0] held_sum = '0;
    logic [2:0]  held_flags = '0;
    while (got < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (was_stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || {sum, cout, ovf, zero} !== {held_sum, held_flags}) begin
          n_fail++; $display("FAIL b2b_stable: got v=%b sum=%h f=%b%b%b expected v=1 sum=%h f=%b", out_valid, sum, cout, ovf, zero, held_sum, held_flags);
        end
      end
      if (!stall_done && sent == 5) begin
        stall_left = 3;
        stall_done = 1;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < 20) begin
        if (!in_valid || last_acc) begin
          a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b expected %b", in_ready, (!out_valid || out_ready));
      end
      if (in_ready === 1'b0) ready_low++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got unexpected result sum=%h expected none", sum);
        end else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== {exp.sum, exp.cout, exp.ovf, exp.zero}) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got sum=%h f=%b%b%b expected sum=%h f=%b%b%b", got, sum, cout, ovf, zero, exp.sum, exp.cout, exp.ovf, exp.zero);
          end
        end
        got++;
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        q.push_back(model(32, a, b, cin, op_sub));
        sent++;
      end
      was_stalled = out_valid && !out_ready;
      held_sum    = sum;
      held_flags  = {cout, ovf, zero};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != 20 || q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d results (%0d pending) expected 20 (0)", got, q.size());
    end
    n_checks++;
    if (ready_low != 3) begin
      n_fail++; $display("FAIL b2b_stall: got in_ready low %0d cycles expected 3", ready_low);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom | 32'h1; b = $urandom; cin = 1'($urandom); op_sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_hs: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_checks++;
    if ({sum, cout, ovf, zero} !== 35'd0) begin
      n_fail++; $display("FAIL midreset_data: got sum=%h f=%b%b%b expected all 0", sum, cout, ovf, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_stale: got %0d stale results expected 0", seen);
    end
  endtask

  task automatic test_small_configs();
    res_t        q4[$], q8[$];
    int          t4[$], t8[$];
    res_t        e;
    int          t;
    int          sent = 0, got4 = 0, got8 = 0, cyc = 0, ready_bad = 0;
    logic [15:0] v;
    logic [7:0]  es;
    while ((got4 < N_SMALL || got8 < N_SMALL) && cyc < 2 * N_SMALL + 100) begin
      @(negedge clk);
      cyc++;
      if (g4_out_valid === 1'b1) begin
        n_checks++;
        if (q4.size() == 0) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL g4_extra: got sum=%h expected none", g4_sum);
        end else begin
          e = q4.pop_front(); t = t4.pop_front(); es = e.sum[7:0];
          if ({g4_sum, g4_cout, g4_ovf, g4_zero} !== {es, e.cout, e.ovf, e.zero} || (cyc - t) != 2) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL g4_result[%0d]: got sum=%h f=%b%b%b lat=%0d expected sum=%h f=%b%b%b lat=2", got4, g4_sum, g4_cout, g4_ovf, g4_zero, cyc - t, es, e.cout, e.ovf, e.zero);
          end
        end
        got4++;
      end
      if (g8_out_valid === 1'b1) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL g8_extra: got sum=%h expected none", g8_sum);
        end else begin
          e = q8.pop_front(); t = t8.pop_front(); es = e.sum[7:0];
          if ({g8_sum, g8_cout, g8_ovf, g8_zero} !== {es, e.cout, e.ovf, e.zero} || (cyc - t) != 1) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL g8_result[%0d]: got sum=%h f=%b%b%b lat=%0d expected sum=%h f=%b%b%b lat=1", got8, g8_sum, g8_cout, g8_ovf, g8_zero, cyc - t, es, e.cout, e.ovf, e.zero);
          end
        end
        got8++;
      end
      if (g4_in_ready !== 1'b1 || g8_in_ready !== 1'b1) ready_bad++;
      if (sent < N_SMALL && $urandom_range(9) != 0) begin
        v = {sent[13:0], 2'($urandom)};
        s_a = v[15:8]; s_b = v[7:0]; s_cin = 1'($urandom); s_op_sub = 1'($urandom);
        s_in_valid = 1'b1;
        e = model(8, s_a, s_b, s_cin, s_op_sub);
        q4.push_back(e); t4.push_back(cyc);
        q8.push_back(e); t8.push_back(cyc);
        sent++;
      end else begin
        s_in_valid = 1'b0;
        s_a = $urandom; s_b = $urandom; s_cin = 1'($urandom); s_op_sub = 1'($urandom);
      end
    end
    s_in_valid = 1'b0;
    n_checks++;
    if (got4 != N_SMALL || got8 != N_SMALL) begin
      n_fail++; $display("FAIL small_count: got g4=%0d g8=%0d expected %0d each", got4, got8, N_SMALL);
    end
    n_checks++;
    if (ready_bad != 0) begin
      n_fail++; $display("FAIL small_in_ready: got %0d cycles with in_ready low expected 0", ready_bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_op_sub = 1'b0; s_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_small_configs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
